// File: rtl/fifo_rd_fwft_if.sv
// Read-side bundle between the FWFT output stage, the read-pointer/RAM logic and the consumer.
// master = the FWFT stage; slave = the pointer/RAM source plus consumer side.
interface fifo_rd_fwft_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [1:0]            occ;

    modport master (
        input  fifo_empty, mem_rdata, dout_ready,
        output rd_en, dout, dout_valid, occ
    );

    modport slave (
        output fifo_empty, mem_rdata, dout_ready,
        input  rd_en, dout, dout_valid, occ
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage: head+skid buffer over a 1-cycle-latency RAM read port.
// Optional FIFO_RD_STATS_EN adds a saturating consumer-underrun counter on port stall_cnt.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 8
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    fifo_rd_fwft_if.master   bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);
    // Handshake: a word moves to the consumer on any rd_clk edge where dout_valid and
    // dout_ready are both high; dout_valid never drops without such a transfer (or reset).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;

    logic       w_valid;
    logic       w_pop;
    logic       w_fill;
    logic [2:0] w_level;
    logic       w_rd_en;

    assign w_valid = (r_state != EMPTY);
    assign w_pop   = w_valid & bus.dout_ready;
    assign w_fill  = r_inflight;
    // Buffered plus in-flight words; a read is only issued if its word is guaranteed a slot.
    assign w_level = {1'b0, r_state} + {2'b00, r_inflight};
    assign w_rd_en = ~rd_rst & ~bus.fifo_empty &
                     ((w_level < 3'd2) | ((w_level == 3'd2) & w_pop));

    assign bus.rd_en      = w_rd_en;
    assign bus.dout       = r_head;
    assign bus.dout_valid = w_valid;
    assign bus.occ        = r_state;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state    <= EMPTY;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            case (r_state)
                EMPTY: begin
                    if (w_fill) begin
                        r_head  <= bus.mem_rdata;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_fill && !w_pop) begin
                        r_skid  <= bus.mem_rdata;
                        r_state <= TWO;
                    end else if (w_fill && w_pop) begin
                        r_head  <= bus.mem_rdata;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head <= r_skid;
                        if (w_fill) begin
                            r_skid <= bus.mem_rdata;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // A word arriving while both slots are held and nothing leaves would be lost.
    a_no_overfill: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !((r_state == TWO) && r_inflight && !w_pop));

`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_stall_cnt <= '0;
        end else if (bus.dout_ready && !w_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
